// File: rtl/dram_device_rsp_pkg.sv
// rtl/dram_device_rsp_pkg.sv - command encoding, bank state type and sizing helper for the DRAM device responder
package dram_pkg;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_ACT = 2'b01;
    localparam logic [1:0] CMD_RW  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        BANK_IDLE        = 2'd0,
        BANK_ACTIVATING  = 2'd1,
        BANK_ACTIVE      = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_state_t;

    // Address width for n entries, never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_device_rsp_if.sv
// rtl/dram_device_rsp_if.sv - controller-to-device command bus and device response signals
interface dram_device_rsp_if #(
    parameter int NUMBER_OF_BANKS = 8,
    parameter int NUMBER_OF_ROWS  = 128,
    parameter int NUMBER_OF_COLS  = 8,
    parameter int DATA_WIDTH      = 1
) ();

    localparam int BANK_W = dram_pkg::addr_width(NUMBER_OF_BANKS);
    localparam int ROW_W  = dram_pkg::addr_width(NUMBER_OF_ROWS);
    localparam int COL_W  = dram_pkg::addr_width(NUMBER_OF_COLS);

    logic [1:0]                 cmd;
    logic [BANK_W-1:0]          cs;
    logic [ROW_W-1:0]           row_addr;
    logic [COL_W-1:0]           col_addr;
    logic                       wr_en;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic [DATA_WIDTH-1:0]      dram_data_out;
    logic                       dram_data_valid;
    logic [NUMBER_OF_BANKS-1:0] bank_open;
    logic                       cmd_err;

    modport master (
        output cmd, cs, row_addr, col_addr, wr_en, wr_data,
        input  dram_data_out, dram_data_valid, bank_open, cmd_err
    );

    modport slave (
        input  cmd, cs, row_addr, col_addr, wr_en, wr_data,
        output dram_data_out, dram_data_valid, bank_open, cmd_err
    );

endinterface

// File: rtl/dram_device_rsp_bank_fsm.sv
// rtl/dram_device_rsp_bank_fsm.sv - one bank's row state, open row and ACT/PRE timer
module dram_bank_fsm #(
    parameter int ROW_W = 7,
    parameter int T_RCD = 2,
    parameter int T_RP  = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             act,
    input  logic             rw,
    input  logic             pre,
    input  logic [ROW_W-1:0] row_addr,
    output logic             is_active,
    output logic [ROW_W-1:0] open_row,
    output logic             illegal
);
    import dram_pkg::*;

    localparam int CNT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W   = addr_width(CNT_MAX);

    bank_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] open_row_q, open_row_d;

    // A bank whose timer has expired is treated as already in its target
    // state, so the command sampled on that edge is accepted.
    logic ready_active;
    logic ready_idle;

    assign ready_active = (state_q == BANK_ACTIVE) ||
                          ((state_q == BANK_ACTIVATING) && (cnt_q == '0));
    assign ready_idle   = (state_q == BANK_IDLE) ||
                          ((state_q == BANK_PRECHARGING) && (cnt_q == '0));

    // State, timer and open-row registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= BANK_IDLE;
            cnt_q      <= '0;
            open_row_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            open_row_q <= open_row_d;
        end
    end

    // Timer advance, then any accepted command overrides it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        open_row_d = open_row_q;
        case (state_q)
            BANK_ACTIVATING: begin
                if (cnt_q == '0) state_d = BANK_ACTIVE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            BANK_PRECHARGING: begin
                if (cnt_q == '0) state_d = BANK_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
        if (act && ready_idle) begin
            state_d    = BANK_ACTIVATING;
            cnt_d      = CNT_W'(T_RCD - 1);
            open_row_d = row_addr;
        end
        if (pre && ready_active) begin
            state_d = BANK_PRECHARGING;
            cnt_d   = CNT_W'(T_RP - 1);
        end
    end

    // Status outputs and command legality for this bank.
    always_comb begin
        is_active = (state_q == BANK_ACTIVE);
        open_row  = open_row_q;
        illegal   = (act && !ready_idle) || (rw && !ready_active) ||
                    (pre && !ready_active);
    end

endmodule

// File: rtl/dram_device_rsp.sv
// rtl/dram_device_rsp.sv - behavioural DRAM device: per-bank FSMs, memory array, CAS read pipeline
module dram_device_rsp #(
    parameter int NUMBER_OF_BANKS = 8,
    parameter int NUMBER_OF_ROWS  = 128,
    parameter int NUMBER_OF_COLS  = 8,
    parameter int DATA_WIDTH      = 1,
    parameter int T_RCD           = 2,
    parameter int T_RP            = 2,
    parameter int T_CL            = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    dram_device_rsp_if.slave  bus
);
    import dram_pkg::*;

    localparam int BANK_W = addr_width(NUMBER_OF_BANKS);
    localparam int ROW_W  = addr_width(NUMBER_OF_ROWS);
    localparam int COL_W  = addr_width(NUMBER_OF_COLS);
    localparam int MEM_AW = BANK_W + ROW_W + COL_W;

    logic [NUMBER_OF_BANKS-1:0] act_sel;
    logic [NUMBER_OF_BANKS-1:0] rw_sel;
    logic [NUMBER_OF_BANKS-1:0] pre_sel;
    logic [NUMBER_OF_BANKS-1:0] bank_active;
    logic [NUMBER_OF_BANKS-1:0] bank_illegal;
    logic [ROW_W-1:0]           bank_row [NUMBER_OF_BANKS];

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    logic                  rw_fire;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [T_CL-1:0]                  pipe_valid_q, pipe_valid_d;
    logic [T_CL-1:0][DATA_WIDTH-1:0]  pipe_data_q,  pipe_data_d;
    logic                             data_valid_q, data_valid_d;
    logic [DATA_WIDTH-1:0]            data_out_q,   data_out_d;
    logic                             cmd_err_q,    cmd_err_d;

    // Route the command only to the bank selected by cs.
    always_comb begin
        act_sel = '0;
        rw_sel  = '0;
        pre_sel = '0;
        for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
            if (bus.cs == BANK_W'(i)) begin
                act_sel[i] = (bus.cmd == CMD_ACT);
                rw_sel[i]  = (bus.cmd == CMD_RW);
                pre_sel[i] = (bus.cmd == CMD_PRE);
            end
        end
    end

    for (genvar g = 0; g < NUMBER_OF_BANKS; g++) begin : g_bank
        dram_bank_fsm #(
            .ROW_W (ROW_W),
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_bank (
            .clk       (clk),
            .rst_b     (rst_b),
            .act       (act_sel[g]),
            .rw        (rw_sel[g]),
            .pre       (pre_sel[g]),
            .row_addr  (bus.row_addr),
            .is_active (bank_active[g]),
            .open_row  (bank_row[g]),
            .illegal   (bank_illegal[g])
        );
    end

    // Accepted RW decode and memory address from the selected bank's open row.
    always_comb begin
        rw_fire  = (bus.cmd == CMD_RW) && !bank_illegal[bus.cs];
        wr_fire  = rw_fire && bus.wr_en && rst_b;
        rd_fire  = rw_fire && !bus.wr_en;
        mem_addr = {bus.cs, bank_row[bus.cs], bus.col_addr};
        rd_data  = mem[mem_addr];
    end

    // Storage array; deliberately not reset, contents persist across reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[mem_addr] <= bus.wr_data;
    end

    // Next values for the read pipeline, output strobe and error pulse.
    always_comb begin
        pipe_valid_d    = '0;
        pipe_data_d     = '0;
        pipe_valid_d[0] = rd_fire;
        pipe_data_d[0]  = rd_fire ? rd_data : '0;
        for (int i = 1; i < T_CL; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
        end
        data_valid_d = pipe_valid_q[T_CL-1];
        data_out_d   = pipe_data_q[T_CL-1];
        cmd_err_d    = |bank_illegal;
    end

    // Response registers; reset flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pipe_valid_q <= '0;
            pipe_data_q  <= '0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            cmd_err_q    <= 1'b0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign bus.dram_data_out   = data_out_q;
    assign bus.dram_data_valid = data_valid_q;
    assign bus.bank_open       = bank_active;
    assign bus.cmd_err         = cmd_err_q;

endmodule

// File: doc/dram_device_rsp.md
# dram_device_rsp

Behavioural DRAM device responder. It sits at the memory end of the `dram_ctrl` command interface, on the opposite side from the controller. It decodes controller commands per bank, enforces per-bank row state and activate/precharge/CAS timing, and stores write data. Read data is returned on `dram_data_out` with fixed CAS latency; that port feeds the controller's `dram_data_in`. It is used as the device model in controller benches and as the reference for controller command legality.

## Interface
- `NUMBER_OF_BANKS`, 8: bank count; must be a power of 2.
- `NUMBER_OF_ROWS`, 128: rows per bank.
- `NUMBER_OF_COLS`, 8: columns per row.
- `DATA_WIDTH`, 1: bits per column.
- `T_RCD`, 2: ACT-to-RW delay in cycles; must be ≥1.
- `T_RP`, 2: PRE-to-ACT delay in cycles; must be ≥1.
- `T_CL`, 2: RW(read)-to-data latency in cycles; must be ≥1.

Ports:
- `clk`  in  1  clock. There is one clock domain; all logic is on the rising edge.
- `rst_b`  in  1  reset, synchronous and active-low.
- `cmd`  in  2  command: 00 NOP, 01 ACT, 10 RW, 11 PRE.
- `cs`  in  clog2(BANKS)  target bank for `cmd`.
- `row_addr`  in  clog2(ROWS)  row to open; sampled on ACT.
- `col_addr`  in  clog2(COLS)  column; sampled on RW.
- `wr_en`  in  1  on RW: 1 means write, 0 means read.
- `wr_data`  in  DATA_WIDTH  write data; sampled on RW with `wr_en`=1.
- `dram_data_out`  out  DATA_WIDTH  read data, to controller `dram_data_in`.
- `dram_data_valid`  out  1  one-cycle strobe qualifying `dram_data_out`.
- `bank_open`  out  BANKS  per-bank bit; 1 when the bank is in ACTIVE.
- `cmd_err`  out  1  one-cycle pulse when an illegal command was dropped.

## Operation
- Each bank has an independent FSM with states IDLE, ACTIVATING, ACTIVE and PRECHARGING, plus an `open_row` register and a down-counter.
- In IDLE, ACT latches `row_addr` into `open_row`, loads the counter with `T_RCD-1`, and moves to ACTIVATING.
- In ACTIVATING, the counter decrements each cycle. At 0 the bank moves to ACTIVE.
- In ACTIVE:
  - RW with `wr_en`=1 writes `wr_data` to mem[cs][open_row][col_addr].
  - RW with `wr_en`=0 pushes mem[cs][open_row][col_addr] into the read pipeline.
  - PRE loads the counter with `T_RP-1` and moves to PRECHARGING.
- In PRECHARGING, the counter decrements each cycle. At 0 the bank moves to IDLE.
- The following commands are illegal: ACT to a non-IDLE bank, RW to a non-ACTIVE bank, and PRE to a non-ACTIVE bank. An illegal command has no effect on state or memory, and `cmd_err` pulses on the next cycle.
- NOP is always legal and has no effect.
- Only the bank selected by `cs` sees the command. Other banks keep advancing their own timers, so bank-parallel ACT/PRE overlap is legal.
- The read pipeline is a `T_CL`-deep shift register of {valid, data}. Back-to-back reads, one per cycle, produce back-to-back valid strobes.
- A write followed by a read of the same location on the next cycle returns the new data, because the write commits at the sampling edge.
- Memory contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset, sampled with `rst_b`=0 at an edge, takes effect at that edge:
  - all banks go to IDLE and all counters to 0;
  - `bank_open`=0, `dram_data_valid`=0, `dram_data_out`=0, `cmd_err`=0;
  - the read pipeline is flushed.
- Reset in mid-operation discards in-flight reads, with no strobe. Commands presented during reset are ignored.
- An ACT sampled at edge k makes the bank ACTIVE after edge k+T_RCD. The earliest legal RW is therefore sampled at edge k+T_RCD. `bank_open` rises after edge k+T_RCD.
- A PRE sampled at edge k drops `bank_open` after edge k and makes the bank IDLE after edge k+T_RP. The earliest legal ACT is sampled at edge k+T_RP.
- A read RW sampled at edge k gives `dram_data_valid`=1 for exactly one cycle, after edge k+T_CL.
- `cmd_err` is registered: illegal command at edge k means the pulse is high after edge k for one cycle.
- A write RW produces no response.

## Structure
- Package `dram_pkg` holds:
  - the `cmd` encoding constants (CMD_NOP, CMD_ACT, CMD_RW, CMD_PRE), shared with `dram_ctrl`;
  - the `bank_state_t` enum.
- Submodule `dram_bank_fsm` holds one bank's state, counter and `open_row`, and is generate-instantiated `NUMBER_OF_BANKS` times.
  - Inputs: its decoded cmd strobes.
  - Outputs: `is_active`, `open_row`, `illegal`.
- The top level holds the memory array, the read pipeline and `cmd_err`.

## Test plan
- **Basic write/read:** reset; ACT b3 r5; then at +2 RW wr b3 c6 d=1; next cycle RW rd b3 c6. Required: `bank_open`[3]=1 after +2; `dram_data_valid` high 2 cycles after the read with data 1; `cmd_err` never asserts.
- **Early RW:** ACT b1 r0, then RW b1 one cycle later (before `T_RCD`). Required: `cmd_err` pulses once, no data strobe, memory unchanged, and a legal read at +2 returns the prior value.
- **Precharge and reopen:** PRE b1, then ACT b1 at +1 → `cmd_err`; ACT b1 at +2 → accepted; `bank_open`[1] rises 2 cycles after the accepted ACT.
- **Bank interleave:** ACT b0 r10 and ACT b7 r20 on consecutive cycles; write c0 in each bank with distinct data; back-to-back reads of both. Required: two consecutive strobes, each carrying its own bank's data.
- **Reset mid-operation:** read in flight, `rst_b`=0 at the next edge. Required: no valid strobe; all `bank_open`=0; a RW immediately after reset → `cmd_err`.
- **Illegal-command sweep:** ACT to an ACTIVE bank and PRE to an IDLE bank each give exactly one `cmd_err` pulse, and `bank_open` is unchanged.
